// File: rtl/ccd_dvp_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ccd_dvp_rx
//  Brief    : AFE sync-interface receiver with crop window and AXI-stream out.
//  Revision : 1.0 - initial release
// ============================================================================
module ccd_dvp_rx #(
    parameter int DW         = 14,
    parameter int CNTW       = 15,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pix_en,
    input  logic            dvp_hsync,
    input  logic            dvp_vsync,
    input  logic [DW-1:0]   dvp_data,
    input  logic [CNTW-1:0] h_start,
    input  logic [CNTW-1:0] h_active,
    input  logic [CNTW-1:0] v_start,
    input  logic [CNTW-1:0] v_active,
    output logic [DW-1:0]   m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tuser,
    output logic            m_axis_tlast,
    input  logic            err_clr,
    output logic            err_overflow,
    output logic            err_short_line,
    output logic [15:0]     frame_cnt,
    output logic            busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DW + 2;
    localparam logic [AW:0] c_fifo_full = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_SKIP      = 2'd2,
        ST_ACTIVE    = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_s_hsync, r_s_vsync, r_p_hsync, r_p_vsync, r_s_pix_en;
    logic [DW-1:0]     r_s_data;
    logic [CNTW-1:0]   r_h_start, r_h_active, r_v_start, r_v_active;
    logic [CNTW-1:0]   r_line_cnt, r_pix_cnt, r_cap_cnt;
    logic              r_sof_pending;
    logic              r_wr_en;
    logic [EW-1:0]     r_wr_data;
    logic              r_err_overflow, r_err_short_line;
    logic [15:0]       r_frame_cnt;

    logic              w_vs_fall, w_hs_fall, w_hs_rise;
    logic [CNTW-1:0]   w_line_idx;
    logic [CNTW:0]     w_v_end;
    logic              w_last, w_skip_done;
    logic              w_restart, w_push, w_set_short, w_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_hsync  <= 1'b1;
            r_s_vsync  <= 1'b1;
            r_p_hsync  <= 1'b1;
            r_p_vsync  <= 1'b1;
            r_s_pix_en <= 1'b0;
            r_s_data   <= '0;
        end else begin
            r_s_hsync  <= dvp_hsync;
            r_s_vsync  <= dvp_vsync;
            r_p_hsync  <= r_s_hsync;
            r_p_vsync  <= r_s_vsync;
            r_s_pix_en <= pix_en;
            r_s_data   <= dvp_data;
        end
    end

    assign w_vs_fall   = r_p_vsync & ~r_s_vsync;
    assign w_hs_fall   = r_p_hsync & ~r_s_hsync;
    assign w_hs_rise   = ~r_p_hsync & r_s_hsync;
    // line_cnt counts hsync falls, so the line now starting is line_cnt-1
    assign w_line_idx  = r_line_cnt - CNTW'(1);
    assign w_v_end     = {1'b0, r_v_start} + {1'b0, r_v_active};
    assign w_last      = (r_cap_cnt == r_h_active - CNTW'(1));
    assign w_skip_done = (r_pix_cnt == r_h_start - CNTW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_restart    = 1'b0;
        w_push       = 1'b0;
        w_set_short  = 1'b0;
        w_frame_done = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_fall) begin
                        w_restart   = 1'b1;
                        w_state_nxt = ST_WAIT_LINE;
                    end
                end
                ST_WAIT_LINE: begin
                    if (w_vs_fall) begin
                        w_restart = 1'b1;
                    end else if (w_hs_rise && (r_line_cnt != '0)) begin
                        if ({1'b0, w_line_idx} >= w_v_end) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end else if (w_line_idx >= r_v_start) begin
                            w_state_nxt = (r_h_start == '0) ? ST_ACTIVE : ST_SKIP;
                        end
                    end
                end
                ST_SKIP, ST_ACTIVE: begin
                    if (w_vs_fall) begin
                        w_set_short = 1'b1;
                        w_restart   = 1'b1;
                        w_state_nxt = ST_WAIT_LINE;
                    end else if (w_hs_fall) begin
                        w_set_short = 1'b1;
                        w_state_nxt = ST_WAIT_LINE;
                    end else if (r_s_pix_en) begin
                        if (r_state == ST_SKIP) begin
                            if (w_skip_done) w_state_nxt = ST_ACTIVE;
                        end else begin
                            w_push = 1'b1;
                            if (w_last) w_state_nxt = ST_WAIT_LINE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_start        <= '0;
            r_h_active       <= '0;
            r_v_start        <= '0;
            r_v_active       <= '0;
            r_sof_pending    <= 1'b0;
            r_line_cnt       <= '0;
            r_pix_cnt        <= '0;
            r_cap_cnt        <= '0;
            r_frame_cnt      <= '0;
            r_wr_en          <= 1'b0;
            r_wr_data        <= '0;
            r_err_short_line <= 1'b0;
        end else begin
            if (w_restart) begin
                r_h_start     <= h_start;
                r_h_active    <= h_active;
                r_v_start     <= v_start;
                r_v_active    <= v_active;
                r_sof_pending <= 1'b1;
            end else if (w_push) begin
                r_sof_pending <= 1'b0;
            end
            if (w_vs_fall)      r_line_cnt <= '0;
            else if (w_hs_fall) r_line_cnt <= r_line_cnt + CNTW'(1);
            if (w_hs_rise) begin
                r_pix_cnt <= '0;
                r_cap_cnt <= '0;
            end else begin
                if (r_s_pix_en && (r_state == ST_SKIP || r_state == ST_ACTIVE))
                    r_pix_cnt <= r_pix_cnt + CNTW'(1);
                if (w_push)
                    r_cap_cnt <= r_cap_cnt + CNTW'(1);
            end
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
            // one register stage between capture and FIFO write
            r_wr_en <= w_push;
            if (w_push) r_wr_data <= {r_sof_pending, w_last, r_s_data};
            if (err_clr)          r_err_short_line <= 1'b0;
            else if (w_set_short) r_err_short_line <= 1'b1;
        end
    end

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_tvalid, w_fifo_wr, w_fifo_rd;
    logic [EW-1:0] w_head;

    // a write into a full FIFO drops even if a pop happens the same cycle
    assign w_fifo_wr   = r_wr_en & (r_count != c_fifo_full);
    assign w_fifo_rd   = r_tvalid & m_axis_tready;
    assign w_count_nxt = r_count + (AW+1)'(w_fifo_wr) - (AW+1)'(w_fifo_rd);

    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_mem[r_wr_ptr] <= r_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_tvalid       <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= w_count_nxt;
            r_tvalid <= (w_count_nxt != '0);
            if (err_clr)                               r_err_overflow <= 1'b0;
            else if (r_wr_en && r_count == c_fifo_full) r_err_overflow <= 1'b1;
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tdata   = r_tvalid ? w_head[DW-1:0] : '0;
    assign m_axis_tlast   = r_tvalid & w_head[DW];
    assign m_axis_tuser   = r_tvalid & w_head[DW+1];
    assign err_overflow   = r_err_overflow;
    assign err_short_line = r_err_short_line;
    assign frame_cnt      = r_frame_cnt;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
